// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage
//   Execute stage of the multi-cycle CPU. Decodes the one-hot ALU control,
//   runs signed DIV on an iterative restoring divider (one quotient bit per
//   cycle), flags misaligned load/store addresses and assembles the
//   EXE->MEM bus. HI holds the remainder of the last completed DIV.
// ---------------------------------------------------------------------------
module exe_stage #(
    parameter int DIV_STEPS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         EXE_valid,
    input  logic [156:0] ID_EXE_bus_r,
    output logic         EXE_over,
    output logic [111:0] EXE_MEM_bus,
    output logic [31:0]  EXE_pc,
    output logic [31:0]  exe_badvaddr,
    output logic         div_busy,
    output logic [31:0]  hi_value
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // ------------------------------------------------------------------
    // Input bus fields
    // ------------------------------------------------------------------
    logic [1:0]  int_type;
    logic        int_flag;
    logic [1:0]  exc_type;
    logic        exc_flag;
    logic [12:0] alu_ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  mem_ctrl;
    logic [31:0] store_data;
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] pc;

    assign {int_type, int_flag, exc_type, exc_flag, alu_ctrl, op1, op2,
            mem_ctrl, store_data, rf_wen, rf_wdest, pc} = ID_EXE_bus_r;

    // An upstream exception or interrupt suppresses DIV and the address check.
    logic upstream_exc;
    assign upstream_exc = exc_flag | int_flag;

    logic div_start;
    assign div_start = EXE_valid & alu_ctrl[12] & ~upstream_exc;

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    logic [31:0] alu_result;

    // Select the result of the one-hot ALU operation; DIV and all-zero give 0 here.
    always_comb begin
        // NOTE: the default assignment ahead of the case keeps every path
        // driving alu_result, so no latch is inferred.
        alu_result = '0;
        case (1'b1)
            alu_ctrl[11]: alu_result = op1 + op2;
            alu_ctrl[10]: alu_result = op1 - op2;
            alu_ctrl[9]:  alu_result = {31'b0, $signed(op1) < $signed(op2)};
            alu_ctrl[8]:  alu_result = {31'b0, op1 < op2};
            alu_ctrl[7]:  alu_result = op1 & op2;
            alu_ctrl[6]:  alu_result = ~(op1 | op2);
            alu_ctrl[5]:  alu_result = op1 | op2;
            alu_ctrl[4]:  alu_result = op1 ^ op2;
            alu_ctrl[3]:  alu_result = op2 << op1[4:0];
            alu_ctrl[2]:  alu_result = op2 >> op1[4:0];
            alu_ctrl[1]:  alu_result = $signed(op2) >>> op1[4:0];
            alu_ctrl[0]:  alu_result = {op2[15:0], 16'b0};
            default:      alu_result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Restoring divider on operand magnitudes
    // ------------------------------------------------------------------
    div_state_e  state_q;
    logic [31:0] dvd_q;      // dividend magnitude, shifted out MSB first
    logic [31:0] dvs_q;      // divisor magnitude
    logic [31:0] rem_q;      // partial remainder magnitude
    logic [31:0] quo_q;      // quotient magnitude, filled LSB first
    logic [4:0]  step_q;
    logic        quo_neg_q;  // operand signs differ
    logic        rem_neg_q;  // dividend was negative
    logic        dbz_q;      // divisor was zero
    logic [31:0] hi_q;

    logic [32:0] rem_shift_d;
    logic [33:0] trial_d;
    logic        quo_bit_d;
    logic [31:0] rem_d;

    // One restoring step: bring down the next dividend bit and trial-subtract.
    always_comb begin
        rem_shift_d = {rem_q, dvd_q[31]};
        trial_d     = {1'b0, rem_shift_d} - {2'b0, dvs_q};
        quo_bit_d   = ~trial_d[33];
        rem_d       = quo_bit_d ? trial_d[31:0] : rem_shift_d[31:0];
    end

    // Signed results; divide-by-zero forces an all-ones quotient.
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    assign div_quotient  = dbz_q     ? 32'hFFFF_FFFF :
                           quo_neg_q ? (32'd0 - quo_q) : quo_q;
    assign div_remainder = rem_neg_q ? (32'd0 - rem_q) : rem_q;

    // Divider FSM: latch magnitudes, iterate DIV_STEPS times, commit HI on DONE.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state_q   <= IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            step_q    <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_start) begin
                        dvd_q     <= op1[31] ? (32'd0 - op1) : op1;
                        dvs_q     <= op2[31] ? (32'd0 - op2) : op2;
                        quo_neg_q <= op1[31] ^ op2[31];
                        rem_neg_q <= op1[31];
                        dbz_q     <= (op2 == 32'd0);
                        rem_q     <= '0;
                        quo_q     <= '0;
                        step_q    <= '0;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (!EXE_valid) begin
                        state_q <= IDLE;
                    end else begin
                        dvd_q  <= {dvd_q[30:0], 1'b0};
                        rem_q  <= rem_d;
                        quo_q  <= {quo_q[30:0], quo_bit_d};
                        step_q <= step_q + 5'd1;
                        if (step_q == 5'(DIV_STEPS - 1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // A flush in DONE leaves HI untouched.
                    if (EXE_valid) begin
                        hi_q <= div_remainder;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result, address check and output bus
    // ------------------------------------------------------------------
    logic        div_done;
    logic [31:0] exe_result;
    logic        misalign;
    logic        exc_flag_o;
    logic [1:0]  exc_type_o;
    logic        rf_wen_o;
    logic [3:0]  mem_ctrl_o;

    assign div_done   = (state_q == DONE);
    assign exe_result = (alu_ctrl[12] && div_done) ? div_quotient : alu_result;

    // Word accesses need addr[1:0]==0, halfword accesses addr[0]==0; bytes never fault.
    assign misalign = ~upstream_exc & (mem_ctrl[3] | mem_ctrl[2]) &
                      ((mem_ctrl[1] & (exe_result[1:0] != 2'b00)) |
                       (mem_ctrl[0] & exe_result[0]));

    assign exc_flag_o = exc_flag | misalign;
    assign exc_type_o = misalign ? 2'b00 : exc_type;
    assign rf_wen_o   = rf_wen & ~upstream_exc & ~misalign;
    assign mem_ctrl_o = misalign ? 4'b0000 : mem_ctrl;

    // A non-excepting DIV completes only in DONE; everything else completes at once.
    assign EXE_over = EXE_valid & ((alu_ctrl[12] & ~upstream_exc) ? div_done : 1'b1);

    assign EXE_MEM_bus  = EXE_valid ? {int_type, int_flag, exc_type_o, exc_flag_o,
                                       mem_ctrl_o, store_data, exe_result,
                                       rf_wen_o, rf_wdest, pc} : '0;
    assign exe_badvaddr = (EXE_valid & misalign) ? exe_result : 32'd0;
    assign EXE_pc       = pc;
    assign div_busy     = (state_q == BUSY);
    assign hi_value     = hi_q;

endmodule

// File: tb/tb_exe_stage.sv
// ---------------------------------------------------------------------------
// tb_exe_stage
//   Scoreboard bench for exe_stage. The driver computes each expected
//   EXE->MEM bus from a plain-arithmetic model and queues it; a monitor
//   pops and compares whenever EXE_over is seen. Latency, busy cycles and
//   HI are checked by the driver after each transaction.
// ---------------------------------------------------------------------------
module tb_exe_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         EXE_valid;
    logic [156:0] ID_EXE_bus_r;
    logic         EXE_over;
    logic [111:0] EXE_MEM_bus;
    logic [31:0]  EXE_pc;
    logic [31:0]  exe_badvaddr;
    logic         div_busy;
    logic [31:0]  hi_value;

    exe_stage dut (
        .clk          (clk),
        .rst          (rst),
        .EXE_valid    (EXE_valid),
        .ID_EXE_bus_r (ID_EXE_bus_r),
        .EXE_over     (EXE_over),
        .EXE_MEM_bus  (EXE_MEM_bus),
        .EXE_pc       (EXE_pc),
        .exe_badvaddr (exe_badvaddr),
        .div_busy     (div_busy),
        .hi_value     (hi_value)
    );

    always #5 clk = ~clk;

    // Operation codes for the model: index of the one-hot alu_ctrl bit, 13 = none.
    localparam logic [3:0] OP_LUI = 4'd0,  OP_SRA = 4'd1,  OP_SLTU = 4'd8,
                            OP_SLT = 4'd9,  OP_ADD = 4'd11, OP_DIV = 4'd12,
                            OP_NONE = 4'd13;

    typedef struct {
        logic [1:0]  int_type;
        logic        int_flag;
        logic [1:0]  exc_type;
        logic        exc_flag;
        logic [3:0]  op;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  mem_ctrl;
        logic [31:0] sd;
        logic        rf_wen;
        logic [4:0]  wdest;
        logic [31:0] pc;
    } txn_t;

    typedef struct {
        logic [111:0] bus;
        logic [31:0]  bad;
        logic [31:0]  pc;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_hi = 32'd0;

    task automatic check(input string name, input logic [111:0] act, input logic [111:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [156:0] pack(input txn_t t);
        logic [12:0] alu;
        alu = (t.op <= 4'd12) ? (13'd1 << t.op) : 13'd0;
        return {t.int_type, t.int_flag, t.exc_type, t.exc_flag, alu, t.op1, t.op2,
                t.mem_ctrl, t.sd, t.rf_wen, t.wdest, t.pc};
    endfunction

    // Reference behaviour computed straight from the operation rules.
    function automatic void model(input txn_t t, output exp_t e,
                                  output logic div_run, output logic [31:0] rem);
        logic [31:0] a, b, r;
        logic        upstream, mis, exc_f, wen;
        logic [1:0]  exc_t;
        logic [3:0]  mem;
        int          sa, sb;
        a = t.op1;
        b = t.op2;
        sa = a;
        sb = b;
        upstream = t.exc_flag | t.int_flag;
        div_run  = (t.op == OP_DIV) && !upstream;
        rem = 32'd0;
        r   = 32'd0;
        case (t.op)
            4'd11: r = a + b;
            4'd10: r = a - b;
            4'd9:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  r = (a < b) ? 32'd1 : 32'd0;
            4'd7:  r = a & b;
            4'd6:  r = ~(a | b);
            4'd5:  r = a | b;
            4'd4:  r = a ^ b;
            4'd3:  r = b << a[4:0];
            4'd2:  r = b >> a[4:0];
            4'd1:  r = $signed(b) >>> a[4:0];
            4'd0:  r = {b[15:0], 16'h0000};
            4'd12: begin
                if (!div_run) begin
                    r = 32'd0;
                end else if (b == 32'd0) begin
                    r = 32'hFFFF_FFFF;
                    rem = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = 32'h8000_0000;
                    rem = 32'd0;
                end else begin
                    r = sa / sb;
                    rem = sa % sb;
                end
            end
            default: r = 32'd0;
        endcase
        mis = !upstream && (t.mem_ctrl[3] || t.mem_ctrl[2]) &&
              ((t.mem_ctrl[1] && r[1:0] != 2'b00) || (t.mem_ctrl[0] && r[0]));
        exc_f = t.exc_flag;
        exc_t = t.exc_type;
        mem   = t.mem_ctrl;
        wen   = upstream ? 1'b0 : t.rf_wen;
        e.bad = 32'd0;
        if (mis) begin
            exc_f = 1'b1;
            exc_t = 2'b00;
            mem   = 4'b0000;
            wen   = 1'b0;
            e.bad = r;
        end
        e.bus = {t.int_type, t.int_flag, exc_t, exc_f, mem, t.sd, r, wen, t.wdest, t.pc};
        e.pc  = t.pc;
    endfunction

    function automatic txn_t mk(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [3:0] mem);
        txn_t t;
        t.int_type = 2'($urandom_range(0, 3));
        t.int_flag = 1'b0;
        t.exc_type = 2'($urandom_range(0, 3));
        t.exc_flag = 1'b0;
        t.op       = op;
        t.op1      = a;
        t.op2      = b;
        t.mem_ctrl = mem;
        t.sd       = $urandom;
        t.rf_wen   = 1'($urandom_range(0, 1));
        t.wdest    = 5'($urandom_range(0, 31));
        t.pc       = $urandom & 32'hFFFF_FFFC;
        return t;
    endfunction

    // Issue one transaction, wait for completion and check timing and HI.
    task automatic run_txn(input txn_t t);
        exp_t        e;
        logic        div_run;
        logic [31:0] rem;
        int          lat;
        int          busy_cnt;
        logic        seen;
        model(t, e, div_run, rem);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        ID_EXE_bus_r = pack(t);
        EXE_valid    = 1'b1;
        lat      = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (div_busy) busy_cnt++;
            if (EXE_over) begin
                lat  = c;
                seen = 1'b1;
                break;
            end
        end
        check("over_seen", {111'b0, seen}, 112'd1);
        if (seen) begin
            check("latency", 112'(lat), div_run ? 112'd33 : 112'd0);
            check("busy_cycles", 112'(busy_cnt), div_run ? 112'd32 : 112'd0);
        end
        @(posedge clk);
        #1;
        EXE_valid = 1'b0;
        if (div_run && seen) model_hi = rem;
        @(negedge clk);
        check("hi_value", {80'b0, hi_value}, {80'b0, model_hi});
    endtask

    // Start a DIV and disturb it in cycle 10 with a flush or a reset.
    task automatic abort_div(input logic use_rst);
        txn_t t;
        t = mk(OP_DIV, 32'd1000, 32'd3, 4'b0000);
        @(posedge clk);
        #1;
        ID_EXE_bus_r = pack(t);
        EXE_valid    = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        if (use_rst) rst = 1'b1;
        else         EXE_valid = 1'b0;
        @(negedge clk);
        check("busy_before_abort", {111'b0, div_busy}, 112'd1);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        EXE_valid = 1'b0;
        if (use_rst) model_hi = 32'd0;
        @(negedge clk);
        check("busy_after_abort", {111'b0, div_busy}, 112'd0);
        check("hi_after_abort", {80'b0, hi_value}, {80'b0, model_hi});
        repeat (40) @(negedge clk);
        check("hi_after_abort_wait", {80'b0, hi_value}, {80'b0, model_hi});
    endtask

    // Monitor: every EXE_over must match the oldest queued expectation.
    always @(negedge clk) begin
        if (EXE_over) begin
            if (sb_q.size() == 0) begin
                check("spurious_over", {111'b0, EXE_over}, 112'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("exe_mem_bus", EXE_MEM_bus, e.bus);
                check("badvaddr", {80'b0, exe_badvaddr}, {80'b0, e.bad});
                check("exe_pc", {80'b0, EXE_pc}, {80'b0, e.pc});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        txn_t t;
        logic [3:0] mems [6];
        mems = '{4'b1010, 4'b1001, 4'b1000, 4'b0110, 4'b0101, 4'b0100};

        rst          = 1'b1;
        EXE_valid    = 1'b0;
        ID_EXE_bus_r = {5{32'hA5A5_5A5A}};
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_over", {111'b0, EXE_over}, 112'd0);
        check("rst_bus", EXE_MEM_bus, 112'd0);
        check("rst_busy", {111'b0, div_busy}, 112'd0);
        check("rst_hi", {80'b0, hi_value}, 112'd0);
        #1;
        rst = 1'b0;

        // Directed cases
        run_txn(mk(OP_ADD, 32'd5, 32'd7, 4'b0000));
        run_txn(mk(OP_SRA, 32'd4, 32'h8000_0000, 4'b0000));
        run_txn(mk(OP_SLT, 32'hFFFF_FFFF, 32'd1, 4'b0000));
        run_txn(mk(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 4'b0000));
        run_txn(mk(OP_LUI, 32'd0, 32'h0000_BEEF, 4'b0000));
        run_txn(mk(OP_NONE, 32'h1234_5678, 32'h9ABC_DEF0, 4'b0000));
        run_txn(mk(OP_DIV, 32'hFFFF_FFF9, 32'd2, 4'b0000));
        run_txn(mk(OP_DIV, 32'h0000_1234, 32'd0, 4'b0000));
        run_txn(mk(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'b0000));
        run_txn(mk(OP_ADD, 32'h1000, 32'd2, 4'b1010));
        t = mk(OP_ADD, 32'h1000, 32'd2, 4'b1010);
        t.exc_flag = 1'b1;
        t.exc_type = 2'b10;
        run_txn(t);
        run_txn(mk(OP_ADD, 32'h1000, 32'd3, 4'b1000));
        run_txn(mk(OP_ADD, 32'h1000, 32'd1, 4'b0101));

        // Aborts: flush keeps HI, reset clears it.
        run_txn(mk(OP_DIV, 32'h0000_1234, 32'd0, 4'b0000));
        abort_div(1'b0);
        abort_div(1'b1);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 13));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                default: ;
            endcase
            t = mk(op, a, b, 4'b0000);
            if (op == OP_ADD && $urandom_range(0, 1) == 1) begin
                t.mem_ctrl = mems[$urandom_range(0, 5)];
                t.op2      = 32'($urandom_range(0, 7));
            end
            if (op != OP_DIV && $urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) t.exc_flag = 1'b1;
                else                           t.int_flag = 1'b1;
            end
            run_txn(t);
        end

        check("sb_empty", 112'(sb_q.size()), 112'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
